// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl (with package RISCV_PKG)
// Brief    : Five-stage pipeline hazard controller: load-use stall, taken
//            branch flush, data-memory wait freeze with sticky timeout flag.
//            Optional macro HAZARD_PERF_CNT_EN adds 32-bit event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package RISCV_PKG;
   localparam int ADDRESS_PORT_WIDTH = 5;
endpackage

module pipeline_hazard_ctrl
   import RISCV_PKG::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_ex_mem_read,
   input  logic [ADDRESS_PORT_WIDTH-1:0] id_ex_rd,
   input  logic [ADDRESS_PORT_WIDTH-1:0] if_id_rs1,
   input  logic [ADDRESS_PORT_WIDTH-1:0] if_id_rs2,
   input  logic                          if_id_rs1_used,
   input  logic                          if_id_rs2_used,
   input  logic                          ex_branch_taken,
   input  logic                          dmem_req,
   input  logic                          dmem_ready,
   output logic                          pc_write_en,
   output logic                          if_id_write_en,
   output logic                          id_ex_write_en,
   output logic                          ex_mem_write_en,
   output logic                          if_id_flush,
   output logic                          id_ex_bubble,
   output logic                          mem_wb_bubble,
   output logic                          mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                   load_stall_cnt,
   output logic [31:0]                   flush_cnt,
   output logic [31:0]                   mem_wait_cnt
`endif
);

   localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        mem_timeout_err_q, mem_timeout_err_d;

   logic freeze;
   logic load_use;
   logic branch_sel;
   logic load_use_sel;

   always_comb begin
      freeze = ((state_q == ST_RUN) && dmem_req && !dmem_ready) ||
               ((state_q == ST_MEM_WAIT) && !dmem_ready);
      load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                 ((if_id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
                  (if_id_rs2_used && (if_id_rs2 == id_ex_rd)));
      branch_sel   = !rst && !freeze && ex_branch_taken;
      load_use_sel = !rst && !freeze && !ex_branch_taken && load_use;
   end

   // Priority: reset, freeze, taken branch, load-use, normal.
   always_comb begin
      pc_write_en     = 1'b1;
      if_id_write_en  = 1'b1;
      id_ex_write_en  = 1'b1;
      ex_mem_write_en = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_bubble    = 1'b0;
      mem_wb_bubble   = 1'b0;
      if (rst) begin
         pc_write_en     = 1'b0;
         if_id_write_en  = 1'b0;
         id_ex_write_en  = 1'b0;
         ex_mem_write_en = 1'b0;
         if_id_flush     = 1'b1;
         id_ex_bubble    = 1'b1;
         mem_wb_bubble   = 1'b1;
      end else if (freeze) begin
         pc_write_en     = 1'b0;
         if_id_write_en  = 1'b0;
         id_ex_write_en  = 1'b0;
         ex_mem_write_en = 1'b0;
         mem_wb_bubble   = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
      end
   end

   always_comb begin
      state_d           = state_q;
      wait_cnt_d        = wait_cnt_q;
      mem_timeout_err_d = mem_timeout_err_q | (wait_cnt_q == TIMEOUT_C);
      case (state_q)
         ST_RUN: begin
            if (dmem_req && !dmem_ready) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = ST_RUN;
            end else if (wait_cnt_q < TIMEOUT_C) begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_RUN;
         wait_cnt_q        <= '0;
         mem_timeout_err_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         wait_cnt_q        <= wait_cnt_d;
         mem_timeout_err_q <= mem_timeout_err_d;
      end
   end

   assign mem_timeout_err = mem_timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] load_stall_cnt_q, load_stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] mem_wait_cnt_q, mem_wait_cnt_d;

   always_comb begin
      load_stall_cnt_d = load_stall_cnt_q + {31'd0, load_use_sel};
      flush_cnt_d      = flush_cnt_q + {31'd0, branch_sel};
      mem_wait_cnt_d   = mem_wait_cnt_q + {31'd0, freeze};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_stall_cnt_q <= '0;
         flush_cnt_q      <= '0;
         mem_wait_cnt_q   <= '0;
      end else begin
         load_stall_cnt_q <= load_stall_cnt_d;
         flush_cnt_q      <= flush_cnt_d;
         mem_wait_cnt_q   <= mem_wait_cnt_d;
      end
   end

   assign load_stall_cnt = load_stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;
   assign mem_wait_cnt   = mem_wait_cnt_q;
`else
   logic unused_sel;
   assign unused_sel = branch_sel ^ load_use_sel;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Table-driven check of pipeline_hazard_ctrl plus wait/timeout/reset
//            sequences. Counter checks compile only with HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   // Output vector order: pc, if_id_we, id_ex_we, ex_mem_we, flush, id_ex_bubble, mem_wb_bubble
   localparam logic [6:0] O_NORMAL = 7'b1111_000;
   localparam logic [6:0] O_LOAD   = 7'b0011_010;
   localparam logic [6:0] O_BRANCH = 7'b1111_110;
   localparam logic [6:0] O_FREEZE = 7'b0000_001;
   localparam logic [6:0] O_RESET  = 7'b0000_111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_ex_mem_read = 1'b0;
   logic [4:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;
   logic       if_id_rs1_used = 1'b0, if_id_rs2_used = 1'b0;
   logic       ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
   logic       pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
   logic       if_id_flush, id_ex_bubble, mem_wb_bubble, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] load_stall_cnt, flush_cnt, mem_wait_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_rd        (id_ex_rd),
      .if_id_rs1       (if_id_rs1),
      .if_id_rs2       (if_id_rs2),
      .if_id_rs1_used  (if_id_rs1_used),
      .if_id_rs2_used  (if_id_rs2_used),
      .ex_branch_taken (ex_branch_taken),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .pc_write_en     (pc_write_en),
      .if_id_write_en  (if_id_write_en),
      .id_ex_write_en  (id_ex_write_en),
      .ex_mem_write_en (ex_mem_write_en),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .mem_wb_bubble   (mem_wb_bubble),
      .mem_timeout_err (mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .load_stall_cnt  (load_stall_cnt),
      .flush_cnt       (flush_cnt),
      .mem_wait_cnt    (mem_wait_cnt)
`endif
   );

   typedef struct {
      logic       rst;
      logic       mem_read;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
      logic       br;
      logic       req;
      logic       rdy;
      logic [6:0] exp;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   function automatic logic [6:0] outs();
      return {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
              if_id_flush, id_ex_bubble, mem_wb_bubble};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic br,
                        input logic rq, input logic rdy);
      rst = r; id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs1 = s1; if_id_rs2 = s2;
      if_id_rs1_used = u1; if_id_rs2_used = u2; ex_branch_taken = br;
      dmem_req = rq; dmem_ready = rdy;
   endtask

   initial begin
      //          rst mr  rd     rs1    rs2    u1 u2 br rq rdy exp
      vecs[0]  = '{1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, O_RESET};
      vecs[1]  = '{0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, O_NORMAL};
      vecs[2]  = '{0, 1, 5'd5,  5'd1,  5'd5,  0, 1, 0, 0, 0, O_LOAD};
      vecs[3]  = '{0, 1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 0, 0, O_NORMAL};
      vecs[4]  = '{0, 1, 5'd7,  5'd7,  5'd2,  0, 1, 0, 0, 0, O_NORMAL};
      vecs[5]  = '{0, 1, 5'd7,  5'd7,  5'd2,  1, 1, 0, 0, 0, O_LOAD};
      vecs[6]  = '{0, 0, 5'd7,  5'd7,  5'd7,  1, 1, 0, 0, 0, O_NORMAL};
      vecs[7]  = '{0, 1, 5'd5,  5'd1,  5'd5,  0, 1, 1, 0, 0, O_BRANCH};
      vecs[8]  = '{0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 0, 0, O_BRANCH};
      vecs[9]  = '{0, 1, 5'd9,  5'd9,  5'd0,  1, 0, 0, 1, 1, O_LOAD};
      vecs[10] = '{0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 1, O_NORMAL};
      vecs[11] = '{0, 1, 5'd5,  5'd5,  5'd5,  1, 1, 0, 0, 0, O_LOAD};
      vecs[12] = '{0, 1, 5'd31, 5'd3,  5'd31, 0, 1, 0, 0, 0, O_LOAD};

      // Initial reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {25'd0, outs()}, {25'd0, O_RESET});
      rst = 1'b0;
      #1;
      chk("post_rst_normal", {25'd0, outs()}, {25'd0, O_NORMAL});
      chk("post_rst_err", {31'd0, mem_timeout_err}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("post_rst_cnt", load_stall_cnt | flush_cnt | mem_wait_cnt, 32'd0);
`endif

      // Table vectors, each held across exactly one rising edge
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].mem_read, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
               vecs[i].rs1_used, vecs[i].rs2_used, vecs[i].br, vecs[i].req, vecs[i].rdy);
         #1;
         chk($sformatf("vec%0d", i), {25'd0, outs()}, {25'd0, vecs[i].exp});
      end
`ifdef HAZARD_PERF_CNT_EN
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("load_stall_cnt", load_stall_cnt, 32'd5);
      chk("flush_cnt", flush_cnt, 32'd2);
`endif

      // Memory wait: 3 frozen cycles (branch + load-use ignored), then release
      @(negedge clk);
      drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0);
      #1 chk("wait_c0", {25'd0, outs()}, {25'd0, O_FREEZE});
      @(negedge clk);
      drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0);
      #1 chk("wait_c1", {25'd0, outs()}, {25'd0, O_FREEZE});
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("wait_c2", {25'd0, outs()}, {25'd0, O_FREEZE});
      @(negedge clk);
      dmem_ready = 1'b1;
      #1 chk("wait_release", {25'd0, outs()}, {25'd0, O_NORMAL});
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("wait_back_run", {25'd0, outs()}, {25'd0, O_NORMAL});
      chk("wait_no_err", {31'd0, mem_timeout_err}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("mem_wait_cnt", mem_wait_cnt, 32'd3);
`endif

      // Timeout with MEM_TIMEOUT=4: counter hits 4 after the 4th MEM_WAIT cycle,
      // flag visible from the 7th frozen cycle onward
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("to_freeze%0d", c), {25'd0, outs()}, {25'd0, O_FREEZE});
         chk($sformatf("to_err%0d", c), {31'd0, mem_timeout_err}, (c >= 6) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      dmem_ready = 1'b1;
      #1 chk("to_release", {25'd0, outs()}, {25'd0, O_NORMAL});
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("to_sticky", {31'd0, mem_timeout_err}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("to_rst_out", {25'd0, outs()}, {25'd0, O_RESET});
      @(negedge clk);
      rst = 1'b0;
      #1 chk("to_cleared", {31'd0, mem_timeout_err}, 32'd0);

      // Reset mid-wait: abandoned, RUN on the first cycle after reset
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("mw_frozen", {25'd0, outs()}, {25'd0, O_FREEZE});
      @(negedge clk);
      drive(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0);
      #1 chk("mw_rst_out", {25'd0, outs()}, {25'd0, O_RESET});
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("mw_run_after", {25'd0, outs()}, {25'd0, O_NORMAL});
`ifdef HAZARD_PERF_CNT_EN
      chk("mw_cnt_clr", mem_wait_cnt, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the data-memory wait cycles before the timeout flag sets (range 1..65535).
REQ-002 The block SHALL use ADDRESS_PORT_WIDTH from RISCV_PKG (value 5) for all register-index ports.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: id_ex_mem_read  input  1  the instruction in EX is a load.
REQ-007 Port: id_ex_rd  input  ADDRESS_PORT_WIDTH  destination register of the EX instruction.
REQ-008 Port: if_id_rs1, if_id_rs2  input  ADDRESS_PORT_WIDTH each  source registers of the ID instruction.
REQ-009 Port: if_id_rs1_used, if_id_rs2_used  input  1 each  the ID instruction reads that source.
REQ-010 Port: ex_branch_taken  input  1  EX has resolved a taken branch or jump this cycle.
REQ-011 Port: dmem_req  input  1  MEM stage is issuing a data-memory access.
REQ-012 Port: dmem_ready  input  1  data memory completes the access this cycle.
REQ-013 Port: pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  output  1 each  pipeline register load enables.
REQ-014 Port: if_id_flush, id_ex_bubble, mem_wb_bubble  output  1 each  insert a NOP into IF/ID, ID/EX or MEM/WB.
REQ-015 Port: mem_timeout_err  output  1  sticky flag; the MEM_TIMEOUT limit was reached.

Function
REQ-016 The FSM SHALL have two states, RUN and MEM_WAIT, held in a register.
REQ-017 RUN -> MEM_WAIT when dmem_req=1 and dmem_ready=0.
REQ-018 MEM_WAIT -> RUN on the first cycle with dmem_ready=1; dmem_req is ignored while in MEM_WAIT.
REQ-019 Freeze is asserted when (RUN and dmem_req and !dmem_ready) or (MEM_WAIT and !dmem_ready).
REQ-020 During freeze: all four write enables=0, mem_wb_bubble=1, if_id_flush=0, id_ex_bubble=0.
REQ-021 During freeze, ex_branch_taken and load-use SHALL be ignored; they are re-evaluated on the release cycle because the EX/ID contents are held.
REQ-022 Load-use is detected when id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd equals a used source (rs1 with rs1_used, or rs2 with rs2_used).
REQ-023 Priority, not frozen: ex_branch_taken first, then load-use, then normal.
REQ-024 Taken branch: pc_write_en=1, if_id_flush=1, id_ex_bubble=1, if_id_write_en=1, id_ex_write_en=1, ex_mem_write_en=1, mem_wb_bubble=0; load-use is suppressed.
REQ-025 Load-use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, id_ex_write_en=1, ex_mem_write_en=1, others=0; exactly one bubble per hazard.
REQ-026 Normal: all write enables=1, all flush/bubble outputs=0.
REQ-027 Control outputs SHALL be combinational from state and inputs (zero latency); only the state, wait counter and flags are registered.
REQ-028 wait_cnt SHALL clear on RUN->MEM_WAIT and increment each MEM_WAIT cycle without dmem_ready, saturating at MEM_TIMEOUT.
REQ-029 When wait_cnt reaches MEM_TIMEOUT, mem_timeout_err SHALL set on the next edge and stay set until reset; the freeze continues.
REQ-030 A dmem_ready in the same cycle as dmem_req in RUN SHALL cause no freeze and no state change.

Reset
REQ-031 rst=1 at an edge: state=RUN, wait_cnt=0, mem_timeout_err=0, and any performance counters=0.
REQ-032 While rst=1, outputs SHALL be: all write enables=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, overriding all inputs.
REQ-033 Reset asserted in MEM_WAIT SHALL abandon the wait; the first cycle after reset is in RUN.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN defined: add outputs load_stall_cnt, flush_cnt and mem_wait_cnt (32 bits each).
REQ-035 With the macro, the counters SHALL increment on load-use cycles (REQ-025), taken-branch cycles (REQ-024) and freeze cycles respectively, and wrap at 2^32.
REQ-036 Macro undefined: these ports and counters SHALL be absent, with identical control behaviour.

Verification
REQ-037 Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, rs2_used=1 -> one cycle with pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
REQ-038 No false stall: id_ex_rd=0 with a match, or rs1 match with rs1_used=0 -> all enables=1, no bubble.
REQ-039 Branch and load-use together: ex_branch_taken=1 plus a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1.
REQ-040 Memory wait: dmem_req=1 with dmem_ready low for 3 cycles -> freeze for exactly 3 cycles, normal enables in the cycle dmem_ready=1; mem_wait_cnt=3 with HAZARD_PERF_CNT_EN defined.
REQ-041 Timeout: MEM_TIMEOUT=4 and dmem_ready held low -> mem_timeout_err=1 after the 4th wait cycle, still set after dmem_ready returns, cleared by rst.
REQ-042 Reset mid-wait: rst pulsed in MEM_WAIT -> RUN next cycle, and the reset output values from REQ-032 hold while rst=1.
